ring_code_decoder: RTL and testbench
====================================

Name: ring_code_decoder

Overview:
- Parametrised successor to the fixed 16-block / 5-dot circular code reader.
- Walks N_BLK x N_DOT sample points around a ring centred at (origin_x, origin_y), using pre-rotated signed offsets from an external offset table.
- Fetches each pixel through the existing pt_req/Ans_valid frame-store handshake, thresholds black dots per block and builds the raw code.
- Adds three behaviours the old block lacks: rotation-invariant code normalisation, image-bounds sample skipping, and a response timeout with an error flag.

Parameters:
- N_BLK, 16: blocks (code bits) per ring, 2..32.
- N_DOT, 5: samples per block, 1..15.
- THRESH, 3: minimum black-dot count for a block to read as 1.
- CW, 10: pixel coordinate width.
- OW, 8: signed offset width.
- IMG_W, 640: image width; valid x is 0..IMG_W-1.
- IMG_H, 480: image height; valid y is 0..IMG_H-1.
- TIMEOUT, 1023: maximum wait cycles for Ans_valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- st_sign  in  1  start pulse; sampled in IDLE only.
- origin_x  in  CW  ring centre x; latched on start.
- origin_y  in  CW  ring centre y; latched on start.
- tab_addr  out  clog2(N_BLK*N_DOT)  offset-table index.
- tab_dx  in  OW  signed x offset; valid 1 cycle after tab_addr.
- tab_dy  in  OW  signed y offset; valid 1 cycle after tab_addr.
- pt_req  out  1  pixel request.
- location_x  out  CW  requested pixel x.
- location_y  out  CW  requested pixel y.
- Ans_valid  in  1  pixel answer strobe.
- pt_pixl_value  in  1  1 = black.
- busy  out  1  high whenever the FSM is not IDLE.
- raw_code  out  N_BLK  code as read; block 0 in the MSB.
- codOUT  out  N_BLK  normalised code (minimum cyclic rotation).
- rot_idx  out  clog2(N_BLK)  rotate-left amount applied to raw_code to produce codOUT.
- complete  out  1  one-cycle done pulse.
- err_timeout  out  1  valid with complete; set when the run aborted.

Behaviour:
- Reset (rst_n=0 at a clk edge): every output and register goes to 0, FSM to IDLE. This includes reset mid-run: no complete pulse and no request afterwards.
- FSM states: IDLE, FETCH, CALC, REQ, NORM, DONE.
- IDLE:
  - On st_sign=1, latch origin_x/origin_y, clear blk, dot, black count and code; go to FETCH.
  - st_sign is ignored in every other state.
- FETCH (1 cycle): drive tab_addr = blk*N_DOT + dot; go to CALC.
- CALC (1 cycle):
  - Compute sx = origin_x + sext(tab_dx) and sy = origin_y + sext(tab_dy) at CW+1 signed bits.
  - In bounds (0 <= sx < IMG_W and 0 <= sy < IMG_H): register location_x/location_y and go to REQ.
  - Out of bounds: count the sample as white, issue no request, and take the advance step directly.
- REQ:
  - pt_req=1 and location stays stable until Ans_valid=1.
  - On Ans_valid: black count += pt_pixl_value, then advance. pt_req drops on the following cycle.
  - Ans_valid outside REQ is ignored.
- Advance step:
  - If dot == N_DOT-1: code = {code[N_BLK-2:0], (count >= THRESH)}, clear count and dot, blk++.
  - Otherwise dot++.
  - After the last dot of block N_BLK-1, go to NORM; otherwise go to FETCH.
- Timeout:
  - A wait counter runs in REQ and clears on entry.
  - If it reaches TIMEOUT with no Ans_valid, go to DONE with err_timeout=1; codOUT, raw_code and rot_idx keep their previous values.
  - If Ans_valid arrives in the same cycle the limit is reached, the answer wins.
- NORM (exactly N_BLK cycles):
  - Cycle k (0..N_BLK-1) compares rotl(code, k) with the best candidate so far.
  - Strictly smaller replaces the best, so on a tie the smallest k is kept.
- DONE (1 cycle):
  - complete=1.
  - On success, register raw_code, codOUT and rot_idx, with err_timeout=0.
  - Return to IDLE.
- Latency: with Ans_valid in the first REQ cycle and all samples in bounds, complete is high exactly 3*N_BLK*N_DOT + N_BLK + 1 cycles after the st_sign sampling edge. The defaults give 257.
- Each out-of-bounds sample shortens the run by 1 cycle.
- Outputs hold their values between runs.

Decomposition:
- Package ring_code_pkg holds:
  - state enum;
  - derived widths: IDX_W = clog2(N_BLK*N_DOT), BLK_W, DOT_W, ROT_W;
  - the rotl function.
- Sub-module code_rot_norm is sequential, one candidate per cycle.
  - Inputs: start, code.
  - Outputs: min_code, min_idx, done.
- The FSM, address generator and bounds check stay in the top module.

Test Plan:
- Defaults, every pixel black, immediate Ans_valid -> raw_code=codOUT=0xFFFF, rot_idx=0, err_timeout=0, complete at cycle 257, exactly 80 pt_req rising edges.
- Blocks 0 and 15 all-black, others white -> raw_code=0x8001, codOUT=0x0003, rot_idx=1.
- Block 3 with 2 black dots, block 4 with 3, rest white -> raw_code=0x0800 (bit 11 set only), codOUT=0x0001, rot_idx=5.
- Responder silent on sample 7 -> err_timeout=1 with complete 1023 cycles after pt_req rises; codOUT unchanged from the prior run; busy low next cycle.
- origin_x=2 and block 0 dx=-5, other samples black -> no pt_req for block 0's 5 samples, raw_code=0x7FFF, run 5 cycles shorter.
- rst_n low for 1 cycle during NORM, then st_sign again -> all outputs 0 after reset, clean full run with correct result; st_sign pulses while busy have no effect.

Source files
------------

// File: rtl/ring_code_pkg.sv
// Shared types and helpers for the ring code reader: FSM states,
// width helpers derived from the ring geometry, and the cyclic rotate.
package ring_code_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CALC  = 3'd2,
        REQ   = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Offset-table index width (IDX_W).
    function automatic int idx_w(input int n_blk, input int n_dot);
        return width_of(n_blk * n_dot);
    endfunction

    // Block counter width (BLK_W).
    function automatic int blk_w(input int n_blk);
        return width_of(n_blk);
    endfunction

    // Dot counter width (DOT_W).
    function automatic int dot_w(input int n_dot);
        return width_of(n_dot);
    endfunction

    // Rotation index width (ROT_W).
    function automatic int rot_w(input int n_blk);
        return width_of(n_blk);
    endfunction

    // Rotate the low n bits of v left by k (0 <= k < n); bits above n are zero.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n, input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                int j;
                j = i + k;
                if (j >= n) j = j - n;
                r[j] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/code_rot_norm.sv
// Minimum-cyclic-rotation search: one candidate rotation per cycle.
// start marks candidate 0; done is high in the cycle of the last candidate,
// where min_code/min_idx already include that candidate.
module code_rot_norm
    import ring_code_pkg::*;
#(
    parameter  int N_BLK = 16,
    localparam int ROT_W = rot_w(N_BLK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BLK-1:0] code,
    output logic [N_BLK-1:0] min_code,
    output logic [ROT_W-1:0] min_idx,
    output logic             done
);

    logic [ROT_W-1:0] k, cur_k;
    logic [N_BLK-1:0] best, cand;
    logic [ROT_W-1:0] best_idx;
    logic             active, take;

    // Current candidate and running minimum; a tie keeps the earlier rotation.
    always_comb begin
        cur_k    = start ? '0 : k;
        cand     = N_BLK'(rotl(32'(code), N_BLK, int'(cur_k)));
        take     = start || (cand < best);
        min_code = take ? cand : best;
        min_idx  = take ? cur_k : best_idx;
        done     = (start || active) && (cur_k == ROT_W'(N_BLK - 1));
    end

    // Step through the rotations until the last one has been compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k        <= '0;
            best     <= '0;
            best_idx <= '0;
            active   <= 1'b0;
        end else if (start || active) begin
            best     <= min_code;
            best_idx <= min_idx;
            k        <= cur_k + 1'b1;
            active   <= !done;
        end
    end

endmodule

// File: rtl/ring_code_decoder.sv
// Circular code reader: walks N_BLK x N_DOT offsets around a ring centre,
// fetches pixels through the frame-store handshake, thresholds each block,
// skips samples outside the image, aborts on a silent frame store and
// reports the code in minimum-rotation form.
module ring_code_decoder
    import ring_code_pkg::*;
#(
    parameter  int N_BLK   = 16,
    parameter  int N_DOT   = 5,
    parameter  int THRESH  = 3,
    parameter  int CW      = 10,
    parameter  int OW      = 8,
    parameter  int IMG_W   = 640,
    parameter  int IMG_H   = 480,
    parameter  int TIMEOUT = 1023,
    localparam int IDX_W   = idx_w(N_BLK, N_DOT),
    localparam int ROT_W   = rot_w(N_BLK)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 st_sign,
    input  logic [CW-1:0]        origin_x,
    input  logic [CW-1:0]        origin_y,
    output logic [IDX_W-1:0]     tab_addr,
    input  logic signed [OW-1:0] tab_dx,
    input  logic signed [OW-1:0] tab_dy,
    output logic                 pt_req,
    output logic [CW-1:0]        location_x,
    output logic [CW-1:0]        location_y,
    input  logic                 Ans_valid,
    input  logic                 pt_pixl_value,
    output logic                 busy,
    output logic [N_BLK-1:0]     raw_code,
    output logic [N_BLK-1:0]     codOUT,
    output logic [ROT_W-1:0]     rot_idx,
    output logic                 complete,
    output logic                 err_timeout
);

    localparam int BLK_W  = blk_w(N_BLK);
    localparam int DOT_W  = dot_w(N_DOT);
    localparam int CNT_W  = width_of(N_DOT + 1);
    localparam int WAIT_W = width_of(TIMEOUT);

    state_t             state, state_n;
    logic [CW-1:0]      ox, oy;
    logic [BLK_W-1:0]   blk;
    logic [DOT_W-1:0]   dot;
    logic [CNT_W-1:0]   cnt, cnt_new;
    logic [N_BLK-1:0]   code;
    logic [WAIT_W-1:0]  wait_cnt;
    logic signed [CW:0] sx, sy;
    logic               in_bnd, adv, px, tmo;
    logic               last_dot, last_smp;
    logic               norm_start, norm_done;
    logic [N_BLK-1:0]   min_code;
    logic [ROT_W-1:0]   min_idx;

    // Sample position one bit wider than the image so negatives are visible.
    assign sx = $signed({1'b0, ox}) + $signed({{(CW + 1 - OW){tab_dx[OW-1]}}, tab_dx});
    assign sy = $signed({1'b0, oy}) + $signed({{(CW + 1 - OW){tab_dy[OW-1]}}, tab_dy});
    assign in_bnd = !sx[CW] && !sy[CW] &&
                    (32'(sx[CW-1:0]) < IMG_W) && (32'(sy[CW-1:0]) < IMG_H);

    assign tab_addr = IDX_W'(int'(blk) * N_DOT + int'(dot));
    assign last_dot = (dot == DOT_W'(N_DOT - 1));
    assign last_smp = last_dot && (blk == BLK_W'(N_BLK - 1));
    assign cnt_new  = cnt + CNT_W'(px);

    assign pt_req   = (state == REQ);
    assign busy     = (state != IDLE);
    assign complete = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state plus the advance / timeout strobes shared with the datapath.
    always_comb begin
        state_n = state;
        adv     = 1'b0;
        px      = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE:  if (st_sign) state_n = FETCH;
            FETCH: state_n = CALC;
            CALC: begin
                if (in_bnd) state_n = REQ;
                else        adv     = 1'b1;   // off-image sample reads as white
            end
            REQ: begin
                if (Ans_valid) begin
                    adv = 1'b1;
                    px  = pt_pixl_value;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_n = DONE;
                end
            end
            NORM:  if (norm_done) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (adv) state_n = last_smp ? NORM : FETCH;
    end

    // Run context, sample walk, code assembly and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ox          <= '0;
            oy          <= '0;
            blk         <= '0;
            dot         <= '0;
            cnt         <= '0;
            code        <= '0;
            wait_cnt    <= '0;
            location_x  <= '0;
            location_y  <= '0;
            norm_start  <= 1'b0;
            raw_code    <= '0;
            codOUT      <= '0;
            rot_idx     <= '0;
            err_timeout <= 1'b0;
        end else begin
            norm_start <= (state_n == NORM) && (state != NORM);
            if (state == IDLE && st_sign) begin
                ox   <= origin_x;
                oy   <= origin_y;
                blk  <= '0;
                dot  <= '0;
                cnt  <= '0;
                code <= '0;
            end
            if (state == CALC && in_bnd) begin
                location_x <= sx[CW-1:0];
                location_y <= sy[CW-1:0];
                wait_cnt   <= '0;
            end
            if (state == REQ && !Ans_valid) wait_cnt <= wait_cnt + 1'b1;
            if (adv) begin
                if (last_dot) begin
                    code <= {code[N_BLK-2:0], (32'(cnt_new) >= THRESH)};
                    cnt  <= '0;
                    dot  <= '0;
                    blk  <= last_smp ? '0 : blk + 1'b1;
                end else begin
                    cnt  <= cnt_new;
                    dot  <= dot + 1'b1;
                end
            end
            if (tmo) err_timeout <= 1'b1;
            if (state == NORM && norm_done) begin
                raw_code    <= code;
                codOUT      <= min_code;
                rot_idx     <= min_idx;
                err_timeout <= 1'b0;
            end
        end
    end

    code_rot_norm #(.N_BLK(N_BLK)) u_norm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (norm_start),
        .code     (code),
        .min_code (min_code),
        .min_idx  (min_idx),
        .done     (norm_done)
    );

endmodule

// File: tb/tb_ring_code_decoder.sv
// Directed bench for ring_code_decoder at default parameters.
module tb_ring_code_decoder;

    logic              clk = 1'b0;
    logic              rst_n, st_sign;
    logic [9:0]        origin_x, origin_y;
    logic [6:0]        tab_addr;
    logic signed [7:0] tab_dx, tab_dy;
    logic              pt_req;
    logic [9:0]        location_x, location_y;
    logic              Ans_valid, pt_pixl_value, busy;
    logic [15:0]       raw_code, codOUT;
    logic [3:0]        rot_idx;
    logic              complete, err_timeout;

    always #5 clk = ~clk;

    ring_code_decoder dut (
        .clk(clk), .rst_n(rst_n), .st_sign(st_sign),
        .origin_x(origin_x), .origin_y(origin_y),
        .tab_addr(tab_addr), .tab_dx(tab_dx), .tab_dy(tab_dy),
        .pt_req(pt_req), .location_x(location_x), .location_y(location_y),
        .Ans_valid(Ans_valid), .pt_pixl_value(pt_pixl_value),
        .busy(busy), .raw_code(raw_code), .codOUT(codOUT), .rot_idx(rot_idx),
        .complete(complete), .err_timeout(err_timeout)
    );

    // Offset table and frame store models.
    logic signed [7:0] tdx [128];
    logic signed [7:0] tdy [128];
    logic              pix [128];
    int                silent_idx = -1;
    int                cur_ox = 0, cur_oy = 0;

    always @(posedge clk) begin
        tab_dx <= tdx[tab_addr];
        tab_dy <= tdy[tab_addr];
    end
    assign Ans_valid     = pt_req && (int'(tab_addr) != silent_idx);
    assign pt_pixl_value = pix[tab_addr];

    // Request edges, wrong locations and complete cycles.
    int   nreq = 0, loc_bad = 0, ncomplete = 0;
    logic req_d = 1'b0;
    always @(negedge clk) begin
        if (pt_req && !req_d) nreq <= nreq + 1;
        if (pt_req && ((int'(location_x) != cur_ox + int'(tdx[tab_addr])) ||
                       (int'(location_y) != cur_oy + int'(tdy[tab_addr]))))
            loc_bad <= loc_bad + 1;
        if (complete) ncomplete <= ncomplete + 1;
        req_d <= pt_req;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_pix(input logic v);
        for (int a = 0; a < 128; a++) pix[a] = v;
    endtask

    // First ndots dots of block b black.
    task automatic set_blk(input int b, input int ndots);
        for (int d = 0; d < 5; d++) pix[b*5 + d] = (d < ndots);
    endtask

    // Launch a run; n ends as the edge count (from the start-sampling edge)
    // after which complete is seen; req_at is the same for the silent sample.
    task automatic run(input int ox, input int oy, input bit poke,
                       output int n, output int req_at);
        cur_ox = ox;
        cur_oy = oy;
        @(negedge clk);
        origin_x = 10'(ox);
        origin_y = 10'(oy);
        st_sign  = 1'b1;
        @(negedge clk);
        st_sign  = 1'b0;
        origin_x = '0;
        origin_y = '0;
        n = 0;
        req_at = -1;
        while (!complete && n < 3000) begin
            if (poke && (n == 40 || n == 200)) begin
                st_sign  = 1'b1;
                origin_x = 10'd100;
                origin_y = 10'd50;
            end else begin
                st_sign = 1'b0;
            end
            @(negedge clk);
            n++;
            if (req_at < 0 && pt_req && int'(tab_addr) == silent_idx) req_at = n;
        end
        st_sign = 1'b0;
        if (!complete) n = -1;
    endtask

    int n, ra, r0, c0;

    initial begin
        rst_n = 1'b0; st_sign = 1'b0; origin_x = '0; origin_y = '0;
        for (int a = 0; a < 128; a++) begin
            tdx[a] = 8'(a % 5 - 2);
            tdy[a] = 8'(a % 7 - 3);
        end
        all_pix(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_raw", 32'(raw_code), 0);
        chk("rst_cod", 32'(codOUT), 0);
        chk("rst_ctl", {27'd0, busy, pt_req, complete, err_timeout, |rot_idx}, 0);
        chk("rst_loc", {location_x, location_y}, 0);
        rst_n = 1'b1;

        // All black, immediate answers.
        all_pix(1'b1);
        r0 = nreq;
        run(300, 200, 1'b0, n, ra);
        chk("t1_lat", n + 1, 257);
        chk("t1_raw", 32'(raw_code), 32'hFFFF);
        chk("t1_cod", 32'(codOUT), 32'hFFFF);
        chk("t1_rot", 32'(rot_idx), 0);
        chk("t1_err", 32'(err_timeout), 0);
        chk("t1_nreq", nreq - r0, 80);
        @(negedge clk);
        chk("t1_busy", {30'd0, busy, complete}, 0);

        // Blocks 0 and 15 black.
        all_pix(1'b0); set_blk(0, 5); set_blk(15, 5);
        run(300, 200, 1'b0, n, ra);
        chk("t2_raw", 32'(raw_code), 32'h8001);
        chk("t2_cod", 32'(codOUT), 32'h0003);
        chk("t2_rot", 32'(rot_idx), 1);

        // Blocks 0 and 8: two equal minima, earliest rotation kept.
        all_pix(1'b0); set_blk(0, 5); set_blk(8, 5);
        run(300, 200, 1'b0, n, ra);
        chk("tie_raw", 32'(raw_code), 32'h8080);
        chk("tie_cod", 32'(codOUT), 32'h0101);
        chk("tie_rot", 32'(rot_idx), 1);

        // Threshold edge: block 3 has 2 dots, block 4 has 3.
        all_pix(1'b0); set_blk(3, 2); set_blk(4, 3);
        run(300, 200, 1'b0, n, ra);
        chk("t3_raw", 32'(raw_code), 32'h0800);
        chk("t3_cod", 32'(codOUT), 32'h0001);
        chk("t3_rot", 32'(rot_idx), 5);
        @(negedge clk);

        // Frame store silent on sample 7.
        all_pix(1'b1);
        silent_idx = 7;
        r0 = nreq;
        run(300, 200, 1'b0, n, ra);
        chk("to_err", 32'(err_timeout), 1);
        chk("to_wait", n - ra, 1023);
        chk("to_nreq", nreq - r0, 8);
        chk("to_raw", 32'(raw_code), 32'h0800);
        chk("to_cod", 32'(codOUT), 32'h0001);
        chk("to_rot", 32'(rot_idx), 5);
        @(negedge clk);
        chk("to_busy", 32'(busy), 0);
        silent_idx = -1;

        // Block 0 entirely left of the image.
        for (int a = 0; a < 5; a++) tdx[a] = -8'sd5;
        r0 = nreq;
        run(2, 200, 1'b0, n, ra);
        chk("oob_lat", n + 1, 252);
        chk("oob_nreq", nreq - r0, 75);
        chk("oob_raw", 32'(raw_code), 32'h7FFF);
        chk("oob_cod", 32'(codOUT), 32'h7FFF);
        chk("oob_err", 32'(err_timeout), 0);
        for (int a = 0; a < 5; a++) tdx[a] = 8'(a % 5 - 2);

        // x = 640 is off-image, y = 0 is on it: dot 4 of every block skipped.
        r0 = nreq;
        run(638, 3, 1'b0, n, ra);
        chk("edge_lat", n + 1, 241);
        chk("edge_nreq", nreq - r0, 64);
        chk("edge_raw", 32'(raw_code), 32'hFFFF);

        // Reset while normalising.
        cur_ox = 300; cur_oy = 200;
        r0 = nreq;
        @(negedge clk);
        origin_x = 10'd300; origin_y = 10'd200; st_sign = 1'b1;
        @(negedge clk);
        st_sign = 1'b0;
        n = 0;
        while (nreq - r0 < 80 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach", 32'(nreq - r0), 80);
        repeat (4) @(negedge clk);
        chk("mid_norm", {30'd0, busy, pt_req}, 32'b10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_raw", 32'(raw_code), 0);
        chk("mid_cod", 32'(codOUT), 0);
        chk("mid_ctl", {27'd0, busy, pt_req, complete, err_timeout, |rot_idx}, 0);
        c0 = ncomplete;
        r0 = nreq;
        repeat (40) @(negedge clk);
        chk("mid_quiet", {ncomplete - c0, nreq - r0}, 0);

        // Clean run with start pulses while busy.
        all_pix(1'b0); set_blk(3, 2); set_blk(4, 3);
        run(300, 200, 1'b1, n, ra);
        chk("poke_lat", n + 1, 257);
        chk("poke_raw", 32'(raw_code), 32'h0800);
        chk("poke_cod", 32'(codOUT), 32'h0001);
        chk("poke_rot", 32'(rot_idx), 5);
        @(negedge clk);
        chk("poke_busy", 32'(busy), 0);

        chk("locations", loc_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
